clk_rst_sequencer: RTL and testbench
====================================

Name: clk_rst_sequencer

Overview:
- Power-up and recovery sequencer for the board PLL clock generator that drives the DDR3 controller and user clocks.
- Pulses the PLL reset, waits for a stable lock, then releases per-domain resets in a fixed staggered order.
- Monitors lock during operation and restarts the full sequence on lock loss or soft request.
- Runs entirely on the free-running 200 MHz board input clock, which also feeds the PLL.

Parameters:
- PLL_RST_CYCLES, 16, cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before a retry (>=2).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock-high cycles required before release (>=1).
- NUM_DOMAINS, 4, number of downstream reset outputs (1..8).
- RST_STAGGER, 64, cycles between successive domain reset releases (>=1).

Ports:
- clk_in1  input  1  free-running 200 MHz board clock; the only clock.
- reset  input  1  asynchronous, active-high; forces the power-up state.
- pll_locked  input  1  PLL LOCKED, asynchronous to clk_in1.
- soft_rst_req  input  1  single-cycle request to restart the full sequence.
- pll_rst  output  1  drives PLL RST.
- domain_rst  output  NUM_DOMAINS  active-high resets; bit 0 is released first. Receivers resynchronize them into their own domains.
- ready  output  1  high only in RUN.
- timeout_err  output  1  sticky flag set on any lock timeout.
- retry_cnt  output  8  number of lock timeouts, saturating at 255.

Behaviour:
- Reset values:
  - pll_rst=1, domain_rst=all 1s, ready=0, timeout_err=0, retry_cnt=0.
  - State=PLL_RST with its counter at 0.
- Lock input: pll_locked passes through a 2-flop synchronizer; lock_s is the second-stage output. All decisions use lock_s, so every reaction to pll_locked has 2 cycles of added latency.
- One shared down/up counter, width sized by $clog2 of the largest count parameter.
- PLL_RST:
  - pll_rst=1, all domain_rst=1.
  - After exactly PLL_RST_CYCLES cycles, go to WAIT_LOCK with counter cleared.
- WAIT_LOCK:
  - pll_rst=0.
  - lock_s=1 -> STABLE, counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 with lock_s=0 -> PLL_RST; set timeout_err; increment retry_cnt (saturating).
- STABLE:
  - Counter increments while lock_s=1.
  - Any lock_s=0 -> WAIT_LOCK with counter cleared. The timeout restarts from 0; this is not a timeout event.
  - LOCK_STABLE_CYCLES consecutive highs -> RELEASE.
- RELEASE:
  - domain_rst[0] deasserts on the first RELEASE cycle.
  - domain_rst[k] deasserts k*RST_STAGGER cycles later.
  - One cycle after the last bit deasserts -> RUN.
  - Bits, once released, stay low unless the sequence restarts.
- RUN:
  - ready=1; outputs are static.
- Restart from any state except PLL_RST:
  - lock_s=0 (in RELEASE or RUN) or soft_rst_req=1 -> PLL_RST next cycle.
  - On the same edge: ready=0, all domain_rst=1, counter cleared.
  - soft_rst_req while already in PLL_RST restarts its counter.
- Simultaneous events:
  - soft_rst_req has priority over all other transitions.
  - A timeout coinciding with soft_rst_req still counts as a timeout.
- timeout_err clears only on reset. retry_cnt is unaffected by soft restarts.
- reset asserted mid-sequence: immediate asynchronous return to the reset values. The synchronizer flops also clear to 0.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: CLK_RST_SEQ_LOSS_CNT_EN.
- Defined:
  - Adds output lock_loss_cnt (16 bits, reset 0, saturating).
  - Increments once per lock_s falling edge detected in RELEASE or RUN.
  - Soft requests and losses in WAIT_LOCK/STABLE do not count.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (parameters PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, NUM_DOMAINS=3, RST_STAGGER=5):
- Clean bring-up:
  - Stimulus: release reset; raise pll_locked 6 cycles after pll_rst falls.
  - Required response: pll_rst high exactly 4 cycles. domain_rst[0] falls 2+8 cycles after pll_locked rises; [1] falls 5 cycles after [0]; [2] falls 5 cycles after [1]. ready rises 1 cycle after [2] falls.
- Timeout and retry:
  - Stimulus: hold pll_locked=0 for 50 cycles.
  - Required response: two 4-cycle pll_rst pulses separated by 20 cycles; timeout_err=1; retry_cnt=2.
- Glitch during STABLE:
  - Stimulus: pll_locked high 5 cycles, low 1 cycle, then high.
  - Required response: no release until 8 consecutive synchronized highs after the glitch; retry_cnt unchanged.
- Lock loss in RUN:
  - Stimulus: drop pll_locked.
  - Required response: 3 cycles later ready=0, domain_rst=3'b111, pll_rst=1. With the macro defined, lock_loss_cnt=1.
- Soft reset in mid-RELEASE:
  - Stimulus: pulse soft_rst_req after domain_rst[0] falls.
  - Required response: next cycle all domain_rst=1 and pll_rst=1; full sequence repeats; retry_cnt unchanged.
- Async reset mid-WAIT_LOCK:
  - Stimulus: assert reset between clock edges.
  - Required response: outputs return to reset values immediately, before the next edge.

Source files
------------

// File: rtl/clk_rst_sequencer.sv
// ---------------------------------------------------------------------------
// clk_rst_sequencer
//
// Power-up and recovery sequencer for the board PLL. It pulses the PLL reset,
// waits for a stable lock, and then releases the downstream domain resets one
// after another in a fixed staggered order. During operation it watches the
// lock signal. It restarts the whole sequence if lock is lost or if a soft
// restart is requested. Everything runs on the free-running board clock,
// which also feeds the PLL, so this block never depends on the PLL output.
//
// Ports:
//   clk_in1        in   free-running board clock (the only clock)
//   reset          in   asynchronous, active-high; forces the power-up state
//   pll_locked     in   PLL LOCKED, asynchronous to clk_in1
//   soft_rst_req   in   single-cycle request to restart the full sequence
//   pll_rst        out  drives PLL RST
//   domain_rst     out  NUM_DOMAINS active-high resets, bit 0 released first
//   ready          out  high only while the sequencer is in RUN
//   timeout_err    out  sticky flag, set on any lock timeout
//   retry_cnt      out  8-bit count of lock timeouts, saturating at 255
//   lock_loss_cnt  out  16-bit saturating count of lock losses seen in
//                       RELEASE or RUN (only present with the macro below)
//
// Optional feature macro: CLK_RST_SEQ_LOSS_CNT_EN
// ---------------------------------------------------------------------------
module clk_rst_sequencer #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int NUM_DOMAINS        = 4,
    parameter int RST_STAGGER        = 64
) (
    input  logic                   clk_in1,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   soft_rst_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   ready,
    output logic                   timeout_err,
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    output logic [15:0]            lock_loss_cnt,
`endif
    output logic [7:0]             retry_cnt
);

    // Span of the release phase: the last domain bit drops at this count.
    localparam int REL_SPAN  = (NUM_DOMAINS - 1) * RST_STAGGER;
    localparam int MAX_A     = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B     = (LOCK_STABLE_CYCLES > REL_SPAN) ? LOCK_STABLE_CYCLES : REL_SPAN;
    localparam int MAX_COUNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);

    // The lock sample that moves the FSM from WAIT_LOCK into STABLE is the
    // first of the required consecutive highs. STABLE therefore needs two
    // fewer counter steps than LOCK_STABLE_CYCLES.
    localparam int STABLE_LAST_I = (LOCK_STABLE_CYCLES >= 2) ? (LOCK_STABLE_CYCLES - 2) : 0;

    localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_LAST_I);
    localparam logic [CNT_W-1:0] REL_LAST     = CNT_W'(REL_SPAN);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cntNext;
    logic [31:0]            w_cntNextWide;
    logic                   r_lockMeta;
    logic                   r_lockS;
    logic                   w_timeout;
    logic                   w_pllRstNext;
    logic [NUM_DOMAINS-1:0] w_domainRstNext;
    logic                   w_readyNext;
    logic                   r_pllRst;
    logic [NUM_DOMAINS-1:0] r_domainRst;
    logic                   r_ready;
    logic                   r_timeoutErr;
    logic [7:0]             r_retryCnt;

    // Two-flop synchronizer for the asynchronous PLL lock input.
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            r_lockMeta <= 1'b0;
            r_lockS    <= 1'b0;
        end else begin
            r_lockMeta <= pll_locked;
            r_lockS    <= r_lockMeta;
        end
    end

    // State register together with the shared phase counter.
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            r_state <= ST_PLL_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Next-state logic. A soft request overrides every other transition.
    // Any exit from a phase clears the counter for the next phase.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        if (soft_rst_req) begin
            w_stateNext = ST_PLL_RST;
            w_cntNext   = '0;
        end else begin
            case (r_state)
                ST_PLL_RST: begin
                    if (r_cnt == PLL_LAST) begin
                        w_stateNext = ST_WAIT_LOCK;
                        w_cntNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (r_lockS) begin
                        w_stateNext = ST_STABLE;
                        w_cntNext   = '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_stateNext = ST_PLL_RST;
                        w_cntNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!r_lockS) begin
                        w_stateNext = ST_WAIT_LOCK;
                        w_cntNext   = '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_stateNext = ST_RELEASE;
                        w_cntNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!r_lockS) begin
                        w_stateNext = ST_PLL_RST;
                        w_cntNext   = '0;
                    end else if (r_cnt == REL_LAST) begin
                        w_stateNext = ST_RUN;
                        w_cntNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!r_lockS) begin
                        w_stateNext = ST_PLL_RST;
                        w_cntNext   = '0;
                    end
                end
                default: begin
                    w_stateNext = ST_PLL_RST;
                    w_cntNext   = '0;
                end
            endcase
        end
    end

    // A timeout is tracked separately from the FSM. This way it still counts
    // when a soft request steals the same edge.
    assign w_timeout     = (r_state == ST_WAIT_LOCK) && !r_lockS && (r_cnt == TIMEOUT_LAST);
    assign w_cntNextWide = 32'(w_cntNext);

    // Output logic. The values are computed from the upcoming state and
    // count, so the registered outputs change on the same edge as the state.
    // During RELEASE, domain bit k drops once the count reaches k*RST_STAGGER.
    always_comb begin
        w_pllRstNext    = 1'b0;
        w_domainRstNext = '1;
        w_readyNext     = 1'b0;
        case (w_stateNext)
            ST_PLL_RST: w_pllRstNext = 1'b1;
            ST_RELEASE: begin
                for (int k = 0; k < NUM_DOMAINS; k++) begin
                    w_domainRstNext[k] = (w_cntNextWide < 32'(k * RST_STAGGER));
                end
            end
            ST_RUN: begin
                w_domainRstNext = '0;
                w_readyNext     = 1'b1;
            end
            default: ;
        endcase
    end

    // Output registers and the sticky error status.
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            r_pllRst     <= 1'b1;
            r_domainRst  <= '1;
            r_ready      <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_retryCnt   <= 8'd0;
        end else begin
            r_pllRst    <= w_pllRstNext;
            r_domainRst <= w_domainRstNext;
            r_ready     <= w_readyNext;
            if (w_timeout) begin
                r_timeoutErr <= 1'b1;
                if (r_retryCnt != 8'hFF) begin
                    r_retryCnt <= r_retryCnt + 8'd1;
                end
            end
        end
    end

    assign pll_rst     = r_pllRst;
    assign domain_rst  = r_domainRst;
    assign ready       = r_ready;
    assign timeout_err = r_timeoutErr;
    assign retry_cnt   = r_retryCnt;

`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    logic [15:0] r_lockLossCnt;
    logic        w_lossEvent;

    // The FSM can only remain in RELEASE or RUN while the lock sample is
    // high. A low sample in those states is therefore always a falling edge.
    assign w_lossEvent = ((r_state == ST_RELEASE) || (r_state == ST_RUN)) && !r_lockS;

    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            r_lockLossCnt <= 16'd0;
        end else if (w_lossEvent && (r_lockLossCnt != 16'hFFFF)) begin
            r_lockLossCnt <= r_lockLossCnt + 16'd1;
        end
    end

    assign lock_loss_cnt = r_lockLossCnt;
`endif

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_clk_rst_sequencer
//
// Directed bench for clk_rst_sequencer, built with a small parameter set
// (4/20/8/3/5). Each scenario task drives its own stimulus and checks timing
// against hand-computed cycle counts.
// ---------------------------------------------------------------------------
module tb_clk_rst_sequencer;

    logic       clk;
    logic       reset;
    logic       pllLocked;
    logic       softRstReq;
    logic       pllRst;
    logic [2:0] domainRst;
    logic       ready;
    logic       timeoutErr;
    logic [7:0] retryCnt;
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    logic [15:0] lockLossCnt;
`endif

    int nCompared;
    int nMismatched;

    clk_rst_sequencer #(
        .PLL_RST_CYCLES    (4),
        .LOCK_TIMEOUT      (20),
        .LOCK_STABLE_CYCLES(8),
        .NUM_DOMAINS       (3),
        .RST_STAGGER       (5)
    ) dut (
        .clk_in1      (clk),
        .reset        (reset),
        .pll_locked   (pllLocked),
        .soft_rst_req (softRstReq),
        .pll_rst      (pllRst),
        .domain_rst   (domainRst),
        .ready        (ready),
        .timeout_err  (timeoutErr),
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
        .lock_loss_cnt(lockLossCnt),
`endif
        .retry_cnt    (retryCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count the edges until a condition holds. The count is -1 if the
    // condition never holds within the bound.
    task automatic waitUntil(input int cond, output int n);
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 200) begin
            tick();
            n++;
            case (cond)
                0: hit = (pllRst === 1'b0);
                1: hit = (pllRst === 1'b1);
                2: hit = (domainRst[0] === 1'b0);
                3: hit = (domainRst[1] === 1'b0);
                4: hit = (domainRst[2] === 1'b0);
                5: hit = (ready === 1'b1);
                default: hit = 1'b1;
            endcase
        end
        if (!hit) n = -1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        pllLocked  = 1'b0;
        softRstReq = 1'b0;
        repeat (3) tick();
        nCompared++; if (pllRst !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_pll_rst: got %b expected 1", pllRst); end
        nCompared++; if (domainRst !== 3'b111) begin nMismatched++; $display("[TB] FAIL reset_domain_rst: got %b expected 111", domainRst); end
        nCompared++; if (ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
        nCompared++; if (timeoutErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", timeoutErr); end
        nCompared++; if (retryCnt !== 8'd0) begin nMismatched++; $display("[TB] FAIL reset_retry_cnt: got %0d expected 0", retryCnt); end
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
        nCompared++; if (lockLossCnt !== 16'd0) begin nMismatched++; $display("[TB] FAIL reset_loss_cnt: got %0d expected 0", lockLossCnt); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_bring_up();
        int n;
        waitUntil(0, n);
        nCompared++; if (n !== 4) begin nMismatched++; $display("[TB] FAIL bringup_pll_rst_len: got %0d expected 4", n); end
        repeat (6) tick();
        pllLocked = 1'b1;
        waitUntil(2, n);
        nCompared++; if (n !== 10) begin nMismatched++; $display("[TB] FAIL bringup_dom0_delay: got %0d expected 10", n); end
        nCompared++; if (domainRst !== 3'b110) begin nMismatched++; $display("[TB] FAIL bringup_dom0_only: got %b expected 110", domainRst); end
        waitUntil(3, n);
        nCompared++; if (n !== 5) begin nMismatched++; $display("[TB] FAIL bringup_dom1_delay: got %0d expected 5", n); end
        waitUntil(4, n);
        nCompared++; if (n !== 5) begin nMismatched++; $display("[TB] FAIL bringup_dom2_delay: got %0d expected 5", n); end
        nCompared++; if (ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL bringup_ready_early: got %b expected 0", ready); end
        waitUntil(5, n);
        nCompared++; if (n !== 1) begin nMismatched++; $display("[TB] FAIL bringup_ready_delay: got %0d expected 1", n); end
        nCompared++; if (timeoutErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL bringup_timeout_err: got %b expected 0", timeoutErr); end
    endtask

    task automatic test_lock_loss_run();
        pllLocked = 1'b0;
        repeat (2) tick();
        nCompared++; if (ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL loss_ready_hold: got %b expected 1", ready); end
        tick();
        nCompared++; if (ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL loss_ready: got %b expected 0", ready); end
        nCompared++; if (domainRst !== 3'b111) begin nMismatched++; $display("[TB] FAIL loss_domain_rst: got %b expected 111", domainRst); end
        nCompared++; if (pllRst !== 1'b1) begin nMismatched++; $display("[TB] FAIL loss_pll_rst: got %b expected 1", pllRst); end
        nCompared++; if (retryCnt !== 8'd0) begin nMismatched++; $display("[TB] FAIL loss_retry_cnt: got %0d expected 0", retryCnt); end
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
        nCompared++; if (lockLossCnt !== 16'd1) begin nMismatched++; $display("[TB] FAIL loss_cnt: got %0d expected 1", lockLossCnt); end
`endif
    endtask

    task automatic test_timeout();
        int n;
        waitUntil(0, n);
        nCompared++; if (n !== 4) begin nMismatched++; $display("[TB] FAIL timeout_pulse1_len: got %0d expected 4", n); end
        waitUntil(1, n);
        nCompared++; if (n !== 20) begin nMismatched++; $display("[TB] FAIL timeout_gap1: got %0d expected 20", n); end
        nCompared++; if (timeoutErr !== 1'b1) begin nMismatched++; $display("[TB] FAIL timeout_err_set: got %b expected 1", timeoutErr); end
        nCompared++; if (retryCnt !== 8'd1) begin nMismatched++; $display("[TB] FAIL timeout_retry1: got %0d expected 1", retryCnt); end
        waitUntil(0, n);
        nCompared++; if (n !== 4) begin nMismatched++; $display("[TB] FAIL timeout_pulse2_len: got %0d expected 4", n); end
        waitUntil(1, n);
        nCompared++; if (n !== 20) begin nMismatched++; $display("[TB] FAIL timeout_gap2: got %0d expected 20", n); end
        nCompared++; if (retryCnt !== 8'd2) begin nMismatched++; $display("[TB] FAIL timeout_retry2: got %0d expected 2", retryCnt); end
    endtask

    task automatic test_glitch();
        int n;
        waitUntil(0, n);
        nCompared++; if (n !== 4) begin nMismatched++; $display("[TB] FAIL glitch_pll_rst_len: got %0d expected 4", n); end
        repeat (2) tick();
        pllLocked = 1'b1;
        repeat (5) tick();
        pllLocked = 1'b0;
        tick();
        pllLocked = 1'b1;
        waitUntil(2, n);
        nCompared++; if (n !== 10) begin nMismatched++; $display("[TB] FAIL glitch_release_delay: got %0d expected 10", n); end
        nCompared++; if (domainRst !== 3'b110) begin nMismatched++; $display("[TB] FAIL glitch_domain_rst: got %b expected 110", domainRst); end
        nCompared++; if (retryCnt !== 8'd2) begin nMismatched++; $display("[TB] FAIL glitch_retry_cnt: got %0d expected 2", retryCnt); end
    endtask

    task automatic test_soft_release();
        int n;
        softRstReq = 1'b1;
        tick();
        softRstReq = 1'b0;
        nCompared++; if (domainRst !== 3'b111) begin nMismatched++; $display("[TB] FAIL soft_domain_rst: got %b expected 111", domainRst); end
        nCompared++; if (pllRst !== 1'b1) begin nMismatched++; $display("[TB] FAIL soft_pll_rst: got %b expected 1", pllRst); end
        repeat (2) tick();
        softRstReq = 1'b1;
        tick();
        softRstReq = 1'b0;
        waitUntil(0, n);
        nCompared++; if (n !== 4) begin nMismatched++; $display("[TB] FAIL soft_restart_pll_rst_len: got %0d expected 4", n); end
        waitUntil(2, n);
        nCompared++; if (n !== 8) begin nMismatched++; $display("[TB] FAIL soft_dom0_delay: got %0d expected 8", n); end
        waitUntil(3, n);
        nCompared++; if (n !== 5) begin nMismatched++; $display("[TB] FAIL soft_dom1_delay: got %0d expected 5", n); end
        waitUntil(4, n);
        nCompared++; if (n !== 5) begin nMismatched++; $display("[TB] FAIL soft_dom2_delay: got %0d expected 5", n); end
        waitUntil(5, n);
        nCompared++; if (n !== 1) begin nMismatched++; $display("[TB] FAIL soft_ready_delay: got %0d expected 1", n); end
        nCompared++; if (retryCnt !== 8'd2) begin nMismatched++; $display("[TB] FAIL soft_retry_cnt: got %0d expected 2", retryCnt); end
        nCompared++; if (timeoutErr !== 1'b1) begin nMismatched++; $display("[TB] FAIL soft_timeout_sticky: got %b expected 1", timeoutErr); end
    endtask

    task automatic test_async_reset();
        int n;
        pllLocked = 1'b0;
        repeat (3) tick();
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
        nCompared++; if (lockLossCnt !== 16'd2) begin nMismatched++; $display("[TB] FAIL areset_loss_cnt_before: got %0d expected 2", lockLossCnt); end
`endif
        waitUntil(0, n);
        nCompared++; if (n !== 4) begin nMismatched++; $display("[TB] FAIL areset_pll_rst_len: got %0d expected 4", n); end
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        nCompared++; if (pllRst !== 1'b1) begin nMismatched++; $display("[TB] FAIL areset_pll_rst: got %b expected 1", pllRst); end
        nCompared++; if (domainRst !== 3'b111) begin nMismatched++; $display("[TB] FAIL areset_domain_rst: got %b expected 111", domainRst); end
        nCompared++; if (timeoutErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL areset_timeout_err: got %b expected 0", timeoutErr); end
        nCompared++; if (retryCnt !== 8'd0) begin nMismatched++; $display("[TB] FAIL areset_retry_cnt: got %0d expected 0", retryCnt); end
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
        nCompared++; if (lockLossCnt !== 16'd0) begin nMismatched++; $display("[TB] FAIL areset_loss_cnt: got %0d expected 0", lockLossCnt); end
`endif
        tick();
        reset = 1'b0;
        waitUntil(0, n);
        nCompared++; if (n !== 4) begin nMismatched++; $display("[TB] FAIL areset_restart_len: got %0d expected 4", n); end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        test_reset();
        test_bring_up();
        test_lock_loss_run();
        test_timeout();
        test_glitch();
        test_soft_release();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
